// File: rtl/dmem_if.sv
// Core-to-data-memory request/response bus for the dmem_responder.
// Handshake: a request (memread|memwrite) is taken at a rising edge only while ready is high;
// the core holds it otherwise. rvalid/err are one-cycle response strobes, rdata is valid with rvalid.
interface dmem_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  memread;
  logic                  memwrite;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  ready;
  logic                  err;

  modport master (
    output memread, memwrite, addr, wdata,
    input  rdata, rvalid, ready, err
  );

  modport slave (
    input  memread, memwrite, addr, wdata,
    output rdata, rvalid, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with programmable wait states and a one-cycle load strobe.
// Optional access checking (misaligned / out of range) is enabled by defining DMEM_ERR_EN.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic       dbg_state,
  output logic [3:0] dbg_cnt
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  lat_rd, lat_wr;
  logic [DATA_WIDTH-1:0] lat_addr, lat_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q, err_q;

  logic                  req;
  logic                  acc_en, acc_rd, acc_wr, acc_err;
  logic [DATA_WIDTH-1:0] acc_addr, acc_wdata;
  logic [AW-1:0]         acc_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  assign req = bus.memread | bus.memwrite;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req && WAIT_STATES != 0) state_nxt = WAIT;
      WAIT: if (cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the live request is serviced at its own edge;
  // otherwise the latched request is serviced on the last stall edge.
  always_comb begin
    bus.ready = (state == IDLE);
    acc_en    = 1'b0;
    acc_rd    = lat_rd;
    acc_wr    = lat_wr;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE && req && WAIT_STATES == 0) begin
      acc_en    = 1'b1;
      acc_rd    = bus.memread & ~bus.memwrite;
      acc_wr    = bus.memwrite;
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
    end else if (state == WAIT && cnt == 4'd1) begin
      acc_en = 1'b1;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];

`ifdef DMEM_ERR_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || (|acc_addr[DATA_WIDTH-1:AW+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[DATA_WIDTH-1:AW+2], acc_addr[1:0]};
  assign acc_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (state == IDLE && req) begin
        lat_rd    <= bus.memread & ~bus.memwrite;
        lat_wr    <= bus.memwrite;
        lat_addr  <= bus.addr;
        lat_wdata <= bus.wdata;
        cnt       <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (acc_en) begin
        err_q <= acc_err;
        if (acc_rd) begin
          rvalid_q <= 1'b1;
          rdata_q  <= acc_err ? '0 : mem[acc_idx];
        end
      end
    end
  end

  // The array has no reset; rst only blocks a write that would land on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && acc_en && acc_wr && !acc_err) mem[acc_idx] <= acc_wdata;
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign dbg_state  = (state == WAIT);
  assign dbg_cnt    = cnt;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 2 and 3 wait states) share one request stream
// and are checked every cycle against a transaction-level model, plus literal timing/data checks.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        memread, memwrite;
  logic [31:0] addr, wdata;

  always #5 clk = ~clk;

  dmem_if #(.DATA_WIDTH(32)) bus0 ();
  dmem_if #(.DATA_WIDTH(32)) bus2 ();
  dmem_if #(.DATA_WIDTH(32)) bus3 ();

  logic       st [3];
  logic [3:0] cn [3];

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .dbg_state(st[0]), .dbg_cnt(cn[0]));
  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .dbg_state(st[1]), .dbg_cnt(cn[1]));
  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .bus(bus3.slave), .dbg_state(st[2]), .dbg_cnt(cn[2]));

  assign bus0.memread = memread;  assign bus0.memwrite = memwrite;
  assign bus0.addr    = addr;     assign bus0.wdata    = wdata;
  assign bus2.memread = memread;  assign bus2.memwrite = memwrite;
  assign bus2.addr    = addr;     assign bus2.wdata    = wdata;
  assign bus3.memread = memread;  assign bus3.memwrite = memwrite;
  assign bus3.addr    = addr;     assign bus3.wdata    = wdata;

  logic [31:0] a_rdata [3];
  logic        a_rvalid [3], a_ready [3], a_err [3];
  assign a_rdata[0] = bus0.rdata; assign a_rvalid[0] = bus0.rvalid;
  assign a_ready[0] = bus0.ready; assign a_err[0]    = bus0.err;
  assign a_rdata[1] = bus2.rdata; assign a_rvalid[1] = bus2.rvalid;
  assign a_ready[1] = bus2.ready; assign a_err[1]    = bus2.err;
  assign a_rdata[2] = bus3.rdata; assign a_rvalid[2] = bus3.rvalid;
  assign a_ready[2] = bus3.ready; assign a_err[2]    = bus3.err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;
  int ws_of [3] = '{0, 2, 3};

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ws%0d at %0t: got %h, expected %h", nm, ws_of[i], $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- model: per instance, a pending access and a stall countdown
  logic [31:0] mem_m [3][256];
  bit          kn    [3][256];
  int          busy  [3];
  bit          p_rd [3], p_wr [3];
  logic [31:0] p_addr [3], p_wdata [3];
  bit          m_rvalid [3], m_err [3], m_kn [3];
  logic [31:0] m_rdata [3];

  task automatic model_access(input int i);
    int  word;
    int  idx;
    bit  e;
    word = int'(p_addr[i] >> 2);
    idx  = word % 256;
`ifdef DMEM_ERR_EN
    e = (p_addr[i] % 4 != 0) || (p_addr[i] >= 32'd1024);
`else
    e = 1'b0;
`endif
    m_err[i] = e;
    if (p_wr[i] && !e) begin
      mem_m[i][idx] = p_wdata[i];
      kn[i][idx]    = 1'b1;
    end
    if (p_rd[i]) begin
      m_rvalid[i] = 1'b1;
      m_rdata[i]  = e ? 32'd0 : mem_m[i][idx];
      m_kn[i]     = e || kn[i][idx];
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      busy[i] = 0; m_kn[i] = 0; m_rdata[i] = '0; m_rvalid[i] = 0; m_err[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        m_rvalid[i] = 1'b0;
        m_err[i]    = 1'b0;
        if (rst) begin
          busy[i]    = 0;
          m_rdata[i] = '0;
          m_kn[i]    = 1'b1;
        end else if (busy[i] == 0) begin
          if (memread || memwrite) begin
            p_rd[i]    = memread && !memwrite;
            p_wr[i]    = memwrite;
            p_addr[i]  = addr;
            p_wdata[i] = wdata;
            if (ws_of[i] == 0) model_access(i);
            else busy[i] = ws_of[i];
          end
        end else begin
          if (busy[i] == 1) model_access(i);
          busy[i]--;
        end
      end
    end
  end

  // ---------------- compare process on the falling edge
  int neg_cnt = 0;
  int rv_at [3], nrv [3], nerr [3], low_cnt [3];
  logic [31:0] rv_data [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      rv_at[i] = -1; nrv[i] = 0; nerr[i] = 0; low_cnt[i] = 0; rv_data[i] = '0;
    end
    forever begin
      @(negedge clk);
      neg_cnt++;
      for (int i = 0; i < 3; i++) begin
        if (a_rvalid[i] === 1'b1) begin
          rv_at[i] = neg_cnt; rv_data[i] = a_rdata[i]; nrv[i]++;
        end
        if (a_err[i] === 1'b1) nerr[i]++;
        if (a_ready[i] === 1'b0) low_cnt[i]++;
        if (chk_on) begin
          check("ready",  i, 32'(a_ready[i]),  32'(busy[i] == 0));
          check("rvalid", i, 32'(a_rvalid[i]), 32'(m_rvalid[i]));
          check("err",    i, 32'(a_err[i]),    32'(m_err[i]));
          check("state",  i, 32'(st[i]),       32'(busy[i] != 0));
          check("cnt",    i, 32'(cn[i]),       32'(busy[i]));
          if (m_kn[i]) check("rdata", i, a_rdata[i], m_rdata[i]);
        end
      end
    end
  end

  // ---------------- driver
  int last_e0;

  task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    memread = rd; memwrite = wr; addr = a; wdata = d;
    @(posedge clk);
    last_e0 = neg_cnt + 1;
    #1;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e, lc0, lc2, nrv0, ne0;
    rst = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    idle(2);
    rst = 1'b0;

    // preload words the later loads rely on
    req(0, 1, 32'h20, 32'h1111_0000); idle(5);
    req(0, 1, 32'h00, 32'h0000_CAFE); idle(5);

    // store then back-to-back load with zero wait states
    lc0 = low_cnt[0];
    req(0, 1, 32'h10, 32'h5);
    req(1, 0, 32'h10, 32'h0);
    e = last_e0;
    idle(5);
    lit("ws0_load_latency", 32'(rv_at[0] - e), 32'd0);
    lit("ws0_load_data",    rv_data[0],        32'h5);
    lit("ws0_ready_low",    32'(low_cnt[0] - lc0), 32'd0);

    // single load seen by every instance
    lc2 = low_cnt[1];
    req(1, 0, 32'h10, 32'h0);
    e = last_e0;
    idle(5);
    lit("ws2_load_latency", 32'(rv_at[1] - e), 32'd2);
    lit("ws2_ready_low",    32'(low_cnt[1] - lc2), 32'd2);
    lit("ws2_load_data",    rv_data[1],        32'h5);
    lit("ws3_load_latency", 32'(rv_at[2] - e), 32'd3);

    // read+write together is a store with no response
    nrv0 = nrv[0];
    req(1, 1, 32'h8, 32'hA5); idle(5);
    lit("both_no_rvalid", 32'(nrv[0] - nrv0), 32'd0);
    req(1, 0, 32'h8, 32'h0); idle(5);
    lit("both_store_ws0", rv_data[0], 32'hA5);
    lit("both_store_ws3", rv_data[2], 32'hA5);

    // reset during the second stall cycle of the 3-wait-state store
    req(0, 1, 32'h20, 32'h1234);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    lit("rst_ws3_ready",  32'(bus3.ready),  32'd1);
    lit("rst_ws3_rvalid", 32'(bus3.rvalid), 32'd0);
    lit("rst_ws3_rdata",  bus3.rdata,       32'd0);
    idle(2);
    req(1, 0, 32'h20, 32'h0); idle(5);
    lit("rst_discard_ws3", rv_data[2], 32'h1111_0000);
    lit("rst_keep_ws0",    rv_data[0], 32'h1234);

    // address beyond the array: wraps, or is rejected when checking is on
    ne0 = nerr[0];
    req(0, 1, 32'h400, 32'hBEEF); idle(5);
    req(1, 0, 32'h0, 32'h0); idle(5);
    req(1, 0, 32'h13, 32'h0); idle(5);
`ifdef DMEM_ERR_EN
    lit("err_pulses",     32'(nerr[0] - ne0), 32'd2);
    lit("misaligned_load", rv_data[0],       32'h0);
`else
    lit("err_never",      32'(nerr[0] - ne0), 32'd0);
    lit("misaligned_load", rv_data[0],       32'h5);
`endif

    // back-to-back store burst then load burst at zero wait states
    for (int i = 0; i < 8; i++) req(0, 1, 32'h40 + 32'(4 * i), 32'h0101_0101 * 32'(i));
    for (int i = 0; i < 8; i++) req(1, 0, 32'h40 + 32'(4 * i), 32'h0);
    idle(6);
    lit("burst_last", rv_data[0], 32'h0707_0707);

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the memory-side end of the core's `memread`/`memwrite` data interface. It accepts word load/store requests addressed by the core's ALU result and stores words in an internal array. Programmable wait states stall the core through `ready`, and load data is returned with a one-cycle `rvalid` strobe. It sits beside `microprocessor_top` and is driven directly by the core's `alu_result`, `memread` and `memwrite`.

## Interface
- `DATA_WIDTH`, 32: data and address width.
- `DEPTH_WORDS`, 256: number of words in the array; power of two; index width `AW = $clog2(DEPTH_WORDS)`.
- `WAIT_STATES`, 0: extra stall cycles per access; legal range 0..15.

Ports, one per line: name, direction, width, meaning. One clock; reset is synchronous and active-high.
- `clk`, in, 1: clock. All state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `memread`, in, 1: load request.
- `memwrite`, in, 1: store request.
- `addr`, in, `DATA_WIDTH`: byte address, driven from the core's `alu_result`.
- `wdata`, in, `DATA_WIDTH`: store data.
- `rdata`, out, `DATA_WIDTH`: load data; valid only while `rvalid` is high.
- `rvalid`, out, 1: one-cycle load-response strobe.
- `ready`, out, 1: high when a new request can be accepted; the core stalls while it is low.
- `err`, out, 1: access-error strobe; tied to 0 when `DMEM_ERR_EN` is undefined.

## Operation

**Array and indexing**
- The array holds `DEPTH_WORDS` x `DATA_WIDTH` bits. Index = `addr[AW+1:2]`.
- The array has no reset.

**State machine**
- States: `IDLE` and `WAIT`. `ready` = (`state == IDLE`).

**IDLE**
- A request is `memread | memwrite` sampled at a rising edge.
- If both are high, the request is a store and the load is dropped: no `rvalid`.
- The request latches `addr` and `wdata`.
- If `WAIT_STATES == 0`, the access is performed at that same edge and the state stays `IDLE`.
- Otherwise the state goes to `WAIT` with `cnt = WAIT_STATES`.

**WAIT**
- `cnt` decrements every edge.
- On the edge where `cnt == 1`, the latched access is performed and the state returns to `IDLE`.
- `memread`/`memwrite` are ignored while in `WAIT`. The core holds its request until `ready` is high, and the new request is then taken as a fresh access.

**Access**
- Store: `mem[idx] <= wdata_latched`.
- Load: `rdata <= mem[idx]` and `rvalid <= 1` for exactly one cycle. `rdata` holds its last value afterwards.

**Reset**
- Reset while in `WAIT` discards the pending access: no array write and no `rvalid`.
- Outputs after reset: `ready` = 1, `rvalid` = 0, `rdata` = 0, `err` = 0, `state` = `IDLE`, `cnt` = 0.

## Timing
- Request sampled at edge E0.
- `ready` is low for exactly `WAIT_STATES` cycles after E0.
- The access is performed at edge E0 + `WAIT_STATES`.
- `rvalid`/`rdata` are visible in the cycle after that edge. Load latency is therefore `WAIT_STATES + 1` cycles.
- With `WAIT_STATES == 0`, back-to-back requests are accepted every cycle: `ready` stays high and `rvalid` follows each load by one cycle.
- A store followed immediately by a load to the same word returns the new data. The store commits before the load's access edge.
- `err` fires at the same edge as the suppressed access, so it is visible in the same cycle an `rvalid` would be.

## Configuration
- Macro: `DMEM_ERR_EN`.
- **Defined:**
  - An access is an error if `addr[1:0] != 0` (misaligned) or `addr[DATA_WIDTH-1:2] >= DEPTH_WORDS` (out of range).
  - An erroneous store does not write the array.
  - An erroneous load returns `rdata` = 0 with `rvalid` = 1.
  - `err` pulses for one cycle. Timing is otherwise unchanged.
- **Undefined:**
  - `addr[1:0]` and the upper address bits are ignored; the index wraps modulo `DEPTH_WORDS`.
  - `err` is constant 0.

## Test plan
1. `WAIT_STATES`=0: store 0x0000_0005 @ 0x10, next cycle load @ 0x10 -> `rvalid`=1 one cycle later, `rdata`=0x0000_0005, `ready` never low.
2. `WAIT_STATES`=2: load @ 0x10 at E0 -> `ready`=0 for 2 cycles, `rvalid`=1 with `rdata`=0x0000_0005 in cycle E0+3, `ready`=1 again in the same cycle.
3. `memread`=`memwrite`=1, `addr`=0x8, `wdata`=0xA5 -> no `rvalid`; a later load @ 0x8 returns 0xA5.
4. `WAIT_STATES`=3: store 0x1234 @ 0x20, assert `rst` during the second stall cycle -> `ready`=1, `rvalid`=0, `rdata`=0; a later load @ 0x20 returns the previous contents.
5. `DEPTH_WORDS`=256, no macro: store 0xBEEF @ 0x400 -> a load @ 0x0 returns 0xBEEF.
6. `DMEM_ERR_EN` defined: store 0xBEEF @ 0x400 and load @ 0x13 -> `err` pulses for each, word 0 unchanged, the load returns `rdata`=0 with `rvalid`=1.
